// File: rtl/ahb_lite_sram_slave_if.sv
// AHB3-Lite bus bundle between a master/decoder and the SRAM slave.
// clk and reset stay outside the bundle as plain module ports.
interface ahb_lite_sram_slave_if #(
    parameter int HADDR_SIZE = 32,
    parameter int HDATA_SIZE = 32
);
    logic                  HSEL;
    logic [HADDR_SIZE-1:0] HADDR;
    logic [HDATA_SIZE-1:0] HWDATA;
    logic [HDATA_SIZE-1:0] HRDATA;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    logic [2:0]            HBURST;
    logic [3:0]            HPROT;
    logic [1:0]            HTRANS;
    logic                  HREADYOUT;
    logic                  HREADY;
    logic                  HRESP;

    modport master (
        output HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HREADY,
        input  HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HREADY,
        output HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/ahb_lite_sram_slave.sv
// Zero-wait-state AHB3-Lite slave in front of a word-organised SRAM array.
// Unsupported, misaligned or out-of-range beats get a two-cycle ERROR response.
module ahb_lite_sram_slave #(
    parameter int          HADDR_SIZE = 32,
    parameter int          HDATA_SIZE = 32,
    parameter int unsigned MEM_DEPTH  = 256
) (
    input logic                  HCLK,
    input logic                  HRESETn,
    ahb_lite_sram_slave_if.slave bus
);
    localparam int IDX_W = $clog2(MEM_DEPTH);

    localparam logic [1:0] ST_OKAY = 2'd0;
    localparam logic [1:0] ST_ERR1 = 2'd1;
    localparam logic [1:0] ST_ERR2 = 2'd2;

    logic [1:0]            state;
    logic                  dp_valid;
    logic                  dp_write;
    logic [IDX_W-1:0]      dp_idx;
    logic [1:0]            dp_lane;
    logic [1:0]            dp_size;
    logic                  accept;
    logic                  addr_err;
    logic [HDATA_SIZE/8-1:0] be;
    logic [HDATA_SIZE-1:0] mem [MEM_DEPTH];
    logic                  unused_inputs;

    assign unused_inputs = ^{bus.HBURST, bus.HPROT, bus.HTRANS[0]};

    assign accept = bus.HSEL & bus.HREADY & bus.HTRANS[1];

    always_comb begin
        addr_err = 1'b0;
        case (bus.HSIZE)
            3'd0:    addr_err = 1'b0;
            3'd1:    addr_err = bus.HADDR[0];
            3'd2:    addr_err = |bus.HADDR[1:0];
            default: addr_err = 1'b1;
        endcase
        if ({2'b00, bus.HADDR[HADDR_SIZE-1:2]} >= HADDR_SIZE'(MEM_DEPTH))
            addr_err = 1'b1;
    end

    // ERR1 drives HREADYOUT low itself, so it must advance regardless of HREADY.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state    <= ST_OKAY;
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_idx   <= '0;
            dp_lane  <= '0;
            dp_size  <= '0;
        end else if (state == ST_ERR1) begin
            state <= ST_ERR2;
        end else if (bus.HREADY) begin
            dp_valid <= accept & ~addr_err;
            state    <= (accept & addr_err) ? ST_ERR1 : ST_OKAY;
            if (accept) begin
                dp_write <= bus.HWRITE;
                dp_idx   <= bus.HADDR[IDX_W+1:2];
                dp_lane  <= bus.HADDR[1:0];
                dp_size  <= bus.HSIZE[1:0];
            end
        end
    end

    always_comb begin
        be = '0;
        case (dp_size)
            2'd0:    be = 4'b0001 << dp_lane;
            2'd1:    be = dp_lane[1] ? 4'b1100 : 4'b0011;
            default: be = '1;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (dp_valid && dp_write && bus.HREADY) begin
            for (int unsigned i = 0; i < HDATA_SIZE / 8; i++) begin
                if (be[i])
                    mem[dp_idx][8*i +: 8] <= bus.HWDATA[8*i +: 8];
            end
        end
    end

    // Combinational read so a write committed on the previous edge is visible.
    assign bus.HRDATA    = (dp_valid && !dp_write) ? mem[dp_idx] : '0;
    assign bus.HREADYOUT = (state != ST_ERR1);
    assign bus.HRESP     = (state != ST_OKAY);
endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Self-checking bench: byte-level reference model of the SRAM plus directed
// scenarios with literal expectations, followed by randomised traffic.
module tb_ahb_lite_sram_slave;
    logic HCLK = 1'b0;
    logic HRESETn = 1'b0;
    logic other_ready = 1'b1;
    logic stall_en = 1'b0;
    logic chk_en = 1'b0;
    int   checks = 0;
    int   errors = 0;

    ahb_lite_sram_slave_if #(.HADDR_SIZE(32), .HDATA_SIZE(32)) bus ();

    ahb_lite_sram_slave #(
        .HADDR_SIZE(32),
        .HDATA_SIZE(32),
        .MEM_DEPTH (256)
    ) dut (
        .HCLK   (HCLK),
        .HRESETn(HRESETn),
        .bus    (bus)
    );

    assign bus.HREADY = bus.HREADYOUT & other_ready;

    always #5 HCLK = ~HCLK;

    // ---------------- reference model ----------------
    typedef enum int {P_NONE, P_READ, P_WRITE, P_ERR1, P_ERR2} phase_t;
    phase_t      pk = P_NONE;
    logic [31:0] pa = '0;
    logic [2:0]  ps = '0;
    logic [7:0]  mref [1024];

    function automatic logic [31:0] word_of(input logic [31:0] a);
        logic [31:0] b;
        b = a & 32'h3FC;
        return {mref[b+3], mref[b+2], mref[b+1], mref[b]};
    endfunction

    function automatic bit is_bad(input logic [31:0] a, input logic [2:0] s);
        if (s > 3'd2) return 1'b1;
        if ((a % (32'd1 << s)) != 0) return 1'b1;
        return a >= 32'd1024;
    endfunction

    initial begin
        for (int i = 0; i < 1024; i++) mref[i] = 8'h00;
        forever begin
            @(posedge HCLK or negedge HRESETn);
            if (!HRESETn) begin
                pk = P_NONE;
            end else if (pk == P_ERR1) begin
                pk = P_ERR2;
            end else if ((pk != P_ERR1) && other_ready) begin
                if (pk == P_WRITE) begin
                    for (int k = 0; k < (1 << ps); k++)
                        mref[pa + k] = bus.HWDATA[8*((pa + k) % 4) +: 8];
                end
                if (bus.HSEL && bus.HTRANS[1]) begin
                    if (is_bad(bus.HADDR, bus.HSIZE)) pk = P_ERR1;
                    else begin
                        pk = bus.HWRITE ? P_WRITE : P_READ;
                        pa = bus.HADDR;
                        ps = bus.HSIZE;
                    end
                end else begin
                    pk = P_NONE;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge HCLK);
            if (chk_en) begin
                check("hreadyout", {31'd0, bus.HREADYOUT}, {31'd0, pk != P_ERR1});
                check("hresp", {31'd0, bus.HRESP}, {31'd0, (pk == P_ERR1) || (pk == P_ERR2)});
                check("hrdata", bus.HRDATA, (pk == P_READ) ? word_of(pa) : 32'd0);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic idle_now();
        bus.HSEL   = 1'b0;
        bus.HTRANS = 2'd0;
    endtask

    // Present one address phase, hold it until accepted, then drive its write data.
    task automatic beat(input logic sel, input logic w, input logic [31:0] a,
                        input logic [2:0] sz, input logic [1:0] tr,
                        input logic [31:0] wd, output int waits);
        logic ok;
        bus.HSEL   = sel;
        bus.HWRITE = w;
        bus.HADDR  = a;
        bus.HSIZE  = sz;
        bus.HTRANS = tr;
        bus.HBURST = 3'($urandom);
        bus.HPROT  = 4'($urandom);
        waits = 0;
        ok = 1'b0;
        for (int n = 0; n < 32 && !ok; n++) begin
            other_ready = stall_en ? ($urandom % 6 != 0) : 1'b1;
            @(negedge HCLK);
            ok = bus.HREADY;
            @(posedge HCLK);
            #1;
            if (!ok) waits++;
        end
        if (!ok) check("hready_timeout", 32'd0, 32'd1);
        bus.HWDATA = w ? wd : $urandom;
    endtask

    task automatic wr(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
        int wt;
        beat(1'b1, 1'b1, a, sz, 2'd2, wd, wt);
    endtask

    task automatic rd(input logic [31:0] a, input logic [2:0] sz, input logic [1:0] tr, output int wt);
        beat(1'b1, 1'b0, a, sz, tr, 32'd0, wt);
    endtask

    task automatic check_err_seq(input string name);
        idle_now();
        #2 check({name, "_c1"}, {30'd0, bus.HREADYOUT, bus.HRESP}, 32'd1);
        @(posedge HCLK); #3;
        check({name, "_c2"}, {30'd0, bus.HREADYOUT, bus.HRESP}, 32'd3);
        @(posedge HCLK); #3;
        check({name, "_c3"}, {30'd0, bus.HREADYOUT, bus.HRESP}, 32'd2);
    endtask

    initial begin
        int wt;
        bus.HSEL = 1'b0; bus.HADDR = '0; bus.HWDATA = '0; bus.HWRITE = 1'b0;
        bus.HSIZE = 3'd0; bus.HBURST = 3'd0; bus.HPROT = 4'd0; bus.HTRANS = 2'd0;

        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        check("reset_state", {bus.HRDATA[29:0], bus.HREADYOUT, bus.HRESP}, 32'd2);
        HRESETn = 1'b1;
        @(posedge HCLK); #1;
        chk_en = 1'b1;

        for (int i = 0; i < 256; i++) wr(32'(i * 4), 3'd2, $urandom);
        wr(32'h000, 3'd2, 32'h01234567);
        wr(32'h040, 3'd2, 32'h11111111);

        // Reset in the middle of a write data phase drops the write.
        wr(32'h040, 3'd2, 32'hCAFEF00D);
        idle_now();
        #2 HRESETn = 1'b0;
        #1 check("rst_async_outputs", {bus.HRDATA[29:0], bus.HREADYOUT, bus.HRESP}, 32'd2);
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        HRESETn = 1'b1;
        @(posedge HCLK); #1;
        check("rst_release", {bus.HRDATA[29:0], bus.HREADYOUT, bus.HRESP}, 32'd2);
        rd(32'h040, 3'd2, 2'd2, wt);
        #2 check("rst_dropped_write", bus.HRDATA, 32'h11111111);

        // Word write then read-after-write on the next address phase.
        wr(32'h010, 3'd2, 32'hDEADBEEF);
        rd(32'h010, 3'd2, 2'd2, wt);
        #2 check("raw_word", bus.HRDATA, 32'hDEADBEEF);
        check("raw_word_resp", {31'd0, bus.HRESP}, 32'd0);
        check("model_word_10", word_of(32'h010), 32'hDEADBEEF);

        // Byte and halfword lane writes merge into one word.
        wr(32'h010, 3'd2, 32'h00000000);
        wr(32'h012, 3'd0, 32'h00AA0000);
        wr(32'h010, 3'd1, 32'h00001234);
        rd(32'h010, 3'd2, 2'd2, wt);
        #2 check("lanes_merge", bus.HRDATA, 32'h00AA1234);
        check("model_lanes", word_of(32'h010), 32'h00AA1234);

        // Misaligned word read.
        rd(32'h012, 3'd2, 2'd2, wt);
        check_err_seq("misaligned");

        // Out-of-range write would alias word 0 if the range check were missing.
        wr(32'h400, 3'd0, 32'h00000055);
        check_err_seq("out_of_range");
        rd(32'h000, 3'd2, 2'd2, wt);
        #2 check("oor_no_write", bus.HRDATA, 32'h01234567);

        // INCR4 write burst then INCR4 read burst, no wait states expected.
        for (int k = 0; k < 4; k++)
            wr(32'h020 + 32'(4 * k), 3'd2, 32'(k + 1));
        for (int k = 0; k < 4; k++) begin
            rd(32'h020 + 32'(4 * k), 3'd2, (k == 0) ? 2'd2 : 2'd3, wt);
            #2 check("burst_rdata", bus.HRDATA, 32'(k + 1));
            check("burst_waits", 32'(wt), 32'd0);
        end
        idle_now();
        @(posedge HCLK); #1;

        // Randomised traffic with external stalls, checked by the model each cycle.
        stall_en = 1'b1;
        for (int n = 0; n < 1500; n++) begin
            logic [2:0]  sz;
            logic [31:0] a;
            logic [1:0]  tr;
            sz = ($urandom % 10 == 0) ? 3'(3 + $urandom % 5) : 3'($urandom % 3);
            a  = $urandom % 1024;
            if ($urandom % 4 != 0 && sz <= 3'd2) a = a & ~((32'd1 << sz) - 1);
            if ($urandom % 16 == 0) a = 32'h400 + ($urandom % 32'h1000);
            tr = ($urandom % 8 == 0) ? 2'($urandom % 2) : 2'(2 + $urandom % 2);
            beat($urandom % 10 != 0, 1'($urandom), a, sz, tr, $urandom, wt);
        end
        idle_now();
        stall_en = 1'b0;
        other_ready = 1'b1;
        repeat (4) @(posedge HCLK);
        @(negedge HCLK);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ahb_lite_sram_slave.md
Name: ahb_lite_sram_slave

Overview:
- Zero-wait-state AHB3-Lite slave backed by an on-chip word-organised SRAM array.
- Sits behind the AHB-Lite decoder and is selected by HSEL.
- Supports byte, halfword and word reads and writes, with little-endian byte lanes.
- Returns a two-cycle ERROR response for unsupported, misaligned or out-of-range transfers.

Parameters:
- HADDR_SIZE, 32, address bus width.
- HDATA_SIZE, 32, data bus width. Only 32 is supported.
- MEM_DEPTH, 256, number of 32-bit words in the array (1 KiB byte range 0x000-0x3FF).

Ports:
- HCLK  in  1  system clock; all logic on rising edge.
- HRESETn  in  1  asynchronous active-low reset.
- HSEL  in  1  slave select from decoder.
- HADDR  in  HADDR_SIZE  byte address (address phase).
- HWDATA  in  HDATA_SIZE  write data (data phase).
- HRDATA  out  HDATA_SIZE  read data (data phase).
- HWRITE  in  1  1=write, 0=read.
- HSIZE  in  3  transfer size: 0=byte, 1=half, 2=word.
- HBURST  in  3  burst type; accepted, ignored.
- HPROT  in  4  protection; accepted, ignored.
- HTRANS  in  2  0=IDLE, 1=BUSY, 2=NONSEQ, 3=SEQ.
- HREADYOUT  out  1  slave ready for the current data phase.
- HREADY  in  1  bus-wide ready (mux of all HREADYOUTs).
- HRESP  out  1  0=OKAY, 1=ERROR.

Behaviour:
- **Reset (async, HRESETn=0):**
  - HREADYOUT=1, HRESP=0, HRDATA=0.
  - All data-phase registers are cleared (valid, write, address, size, error state).
  - Array contents are not reset.
  - A pending write data phase is dropped.
- **Address-phase acceptance:**
  - A transfer is accepted on a rising edge when HSEL=1, HREADY=1 and HTRANS[1]=1 (NONSEQ or SEQ).
  - On acceptance, HWRITE, HADDR and HSIZE are registered.
  - IDLE, BUSY or HSEL=0 transfers produce an OKAY zero-wait response (HREADYOUT=1, HRESP=0) and have no side effects.
- **Error detection, evaluated at acceptance:**
  - HSIZE>2.
  - HSIZE=1 with HADDR[0]=1.
  - HSIZE=2 with HADDR[1:0]!=0.
  - HADDR[HADDR_SIZE-1:2] >= MEM_DEPTH.
- **Error response:**
  - Cycle 1: HREADYOUT=0, HRESP=1.
  - Cycle 2: HREADYOUT=1, HRESP=1.
  - Then return to HREADYOUT=1, HRESP=0.
  - No array write occurs; HRDATA=0.
  - No new address phase is sampled in cycle 1, because HREADY is low.
- **OKAY write:**
  - The data phase is the cycle after acceptance, with HREADYOUT=1.
  - On the edge ending the data phase, only the lanes selected by the registered size and address bits are written.
  - Byte: lane HADDR[1:0]. Half: lanes {HADDR[1],0} and {HADDR[1],1}. Word: all 4 lanes.
  - The bytes are taken from the matching HWDATA lanes.
- **OKAY read:**
  - During the data phase, HRDATA = the full 32-bit array word at the registered word index (combinational from the registered address). HREADYOUT=1.
  - The master extracts the lanes it needs.
  - Outside OKAY read data phases, HRDATA=0.
- **Pipelining:**
  - Back-to-back transfers are supported; a write data phase and the next address phase overlap.
  - Read-after-write to the same word on consecutive transfers returns the newly written data, because the write commits on the edge that starts the read data phase.
- **Bursts:** Address sequencing is the master's responsibility. HBURST is ignored; each beat is checked independently.
- **HREADY=0 from another slave:** No acceptance occurs and the registered state holds.

Test Plan:
1. Reset asserted mid-write, then released with HTRANS=IDLE -> HREADYOUT=1, HRESP=0, HRDATA=0; the dropped write leaves its target word unchanged.
2. Word write 0xDEADBEEF to 0x010, then word read at 0x010 on the next address phase -> HRDATA=0xDEADBEEF in the read data phase, HRESP=0.
3. Byte write 0xAA to 0x012, then halfword write 0x1234 to 0x010, then word read of 0x010 -> 0x00AA1234. Precondition: word 0x010 preloaded with 0x00000000.
4. Misaligned word read at 0x012 -> HREADYOUT=0/HRESP=1, then HREADYOUT=1/HRESP=1, then OKAY.
5. Out-of-range write of 0x55 at 0x400 -> two-cycle ERROR response; no array word is modified.
6. INCR4 burst: NONSEQ 0x020 then SEQ 0x024, 0x028, 0x02C, writing 1,2,3,4, followed by an INCR4 read -> HRDATA sequence 1,2,3,4, zero wait states.
